// File: rtl/cpu_pkg.sv
// Shared core types: opcode constants, XLEN and the fetch queue entry layout.
// Optional field illegal is present only when IFQ_OPCODE_CHECK_EN is defined.
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
`ifdef IFQ_OPCODE_CHECK_EN
      logic            illegal;
`endif
   } fetch_entry_t;

`ifdef IFQ_OPCODE_CHECK_EN
   function automatic logic opcode_illegal(input logic [6:0] op);
      return !(op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI});
   endfunction
`endif

endpackage

// File: rtl/ifq_fifo.sv
// Generic synchronous FIFO, circular pointers, flush and occupancy count.
// Head visible combinationally; write into a full FIFO is the caller's responsibility.
module ifq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       flush,
   input  logic                       wr_vld,
   input  logic [WIDTH-1:0]           wr_dat,
   input  logic                       rd_rdy,
   output logic [WIDTH-1:0]           rd_dat,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;

   // Storage is cleared on reset so the head reads as zero before the first fill.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_vld) begin
            mem[wr_ptr] <= wr_dat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (rd_rdy) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_vld, rd_rdy})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign rd_dat = mem[rd_ptr];
   assign count  = cnt;
   assign full   = (cnt == CW'(DEPTH));
   assign empty  = (cnt == '0);

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch PC generator and instruction buffer feeding decode; IFQ_OPCODE_CHECK_EN adds deq_illegal.
// Latency: request to deq_valid is 2 cycles, redirect to deq_valid is 3 cycles.
// Backpressure: issue stalls while count + in-flight reaches DEPTH; redirect blocks issue and dequeue.
module instr_fetch_queue
   import cpu_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       rstn,
   output logic                       imem_req,
   output logic [XLEN-1:0]            imem_addr,
   input  logic [XLEN-1:0]            imem_rdata,
   input  logic                       redirect_valid,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic                       deq_valid,
   input  logic                       deq_ready,
   output logic [XLEN-1:0]            deq_instr,
   output logic [XLEN-1:0]            deq_pc,
`ifdef IFQ_OPCODE_CHECK_EN
   output logic                       deq_illegal,
`endif
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH+1);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] inflight_pc_q;
   logic            inflight_q;
   logic [CW:0]     occ;
   logic            push;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;
   fetch_entry_t    wr_entry;
   fetch_entry_t    head;
   logic            unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   // An outstanding read already owns a slot, so it counts against capacity.
   assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight_q};
   assign imem_req  = !redirect_valid && (occ < (CW+1)'(DEPTH));
   assign imem_addr = pc_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else if (redirect_valid) begin
         pc_q       <= {redirect_pc[XLEN-1:2], 2'b00};
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= imem_req;
         if (imem_req) begin
            pc_q          <= pc_q + 32'd4;
            inflight_pc_q <= pc_q;
         end
      end
   end

   assign push = inflight_q && !redirect_valid;

   always_comb begin
      wr_entry       = '0;
      wr_entry.instr = imem_rdata;
      wr_entry.pc    = inflight_pc_q;
`ifdef IFQ_OPCODE_CHECK_EN
      wr_entry.illegal = opcode_illegal(imem_rdata[6:0]);
`endif
   end

   assign deq_valid = !fifo_empty && !redirect_valid;
   assign pop       = deq_valid && deq_ready;

   ifq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk    (clk),
      .rstn   (rstn),
      .flush  (redirect_valid),
      .wr_vld (push),
      .wr_dat (wr_entry),
      .rd_rdy (pop),
      .rd_dat (head),
      .count  (count),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign deq_instr = head.instr;
   assign deq_pc    = head.pc;
`ifdef IFQ_OPCODE_CHECK_EN
   assign deq_illegal = head.illegal;
`endif

   // Credit accounting must never let a returning word find the buffer full.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && fifo_full));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: stream, backpressure, redirects, wrap, mid-run reset.
module tb_instr_fetch_queue;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        illegal;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        deq_valid;
   logic        deq_ready;
   logic [31:0] deq_instr;
   logic [31:0] deq_pc;
   logic [2:0]  count;
`ifdef IFQ_OPCODE_CHECK_EN
   logic        deq_illegal;
`endif

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_pops = 0;
   int   base;

   always #5 clk = ~clk;

   instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .deq_valid      (deq_valid),
      .deq_ready      (deq_ready),
      .deq_instr      (deq_instr),
      .deq_pc         (deq_pc),
`ifdef IFQ_OPCODE_CHECK_EN
      .deq_illegal    (deq_illegal),
`endif
      .count          (count)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_1000) return 32'h0000_0073;
      if (a == 32'h0000_1004) return 32'h0000_0013;
      return a;
   endfunction

   function automatic logic exp_ill(input logic [31:0] w);
      case (w[6:0])
         7'h33, 7'h13, 7'h03, 7'h23, 7'h37: return 1'b0;
         default:                           return 1'b1;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic expect_run(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.pc      = start + 32'(4 * i);
         e.instr   = mem_word(e.pc);
         e.illegal = exp_ill(e.instr);
         exp_q.push_back(e);
      end
   endtask

   task automatic drv();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic check_reset();
      check("rst_imem_req", imem_req, 1);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_deq_valid", deq_valid, 0);
      check("rst_count", count, 0);
      check("rst_deq_instr", deq_instr, 0);
      check("rst_deq_pc", deq_pc, 0);
`ifdef IFQ_OPCODE_CHECK_EN
      check("rst_deq_illegal", deq_illegal, 0);
`endif
   endtask

   // Synchronous instruction memory: data one cycle after the request.
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= mem_word(imem_addr);
   end

   always @(negedge clk) begin
      if (rstn && deq_valid && deq_ready) begin
         n_pops++;
         if (exp_q.size() == 0) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("deq_pc", deq_pc, e.pc);
            check("deq_instr", deq_instr, e.instr);
`ifdef IFQ_OPCODE_CHECK_EN
            check("deq_illegal", deq_illegal, e.illegal);
`endif
         end
      end
   end

   initial begin
      #200000;
      check("timeout", 0, 1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      rstn           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      deq_ready      = 1'b1;
      repeat (3) @(posedge clk);
      smp();
      check_reset();
      expect_run(32'h0, 40);
      rstn = 1'b1;

      // Stream: first data in cycle 1, first dequeue in cycle 2.
      smp();
      check("c1_deq_valid", deq_valid, 0);
      check("c1_count", count, 0);
      smp();
      check("c2_deq_valid", deq_valid, 1);
      check("c2_deq_pc", deq_pc, 32'h0);
      for (int i = 3; i <= 5; i++) begin
         smp();
         check("stream_vld", deq_valid, 1);
         check("stream_count", count, 1);
      end

      // Backpressure for 10 cycles.
      drv();
      deq_ready = 1'b0;
      for (int i = 6; i <= 15; i++) begin
         smp();
         if (i >= 9) begin
            check("bp_count", count, 4);
            check("bp_req", imem_req, 0);
         end
      end
      drv();
      deq_ready = 1'b1;
      smp();
      check("bp_req_full", imem_req, 0);
      check("bp_head", deq_pc, 32'h10);
      smp();
      check("bp_req_resume", imem_req, 1);
      check("bp_addr", imem_addr, 32'h20);
      repeat (8) smp();

      // Redirect while the read of 0x8 is in flight.
      drv();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      exp_q.delete();
      expect_run(32'h0, 1);
      base = n_pops;
      drv();
      redirect_valid = 1'b0;
      drv();
      drv();
      smp();
      check("rd_req8", imem_req, 1);
      check("rd_addr8", imem_addr, 32'h8);
      drv();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0203;
      exp_q.delete();
      expect_run(32'h200, 20);
      smp();
      check("rd_t_deq_valid", deq_valid, 0);
      check("rd_t_req", imem_req, 0);
      check("rd_pops", 32'(n_pops - base), 1);
      drv();
      redirect_valid = 1'b0;
      smp();
      check("rd_t1_count", count, 0);
      check("rd_t1_req", imem_req, 1);
      check("rd_t1_addr", imem_addr, 32'h200);
      check("rd_t1_vld", deq_valid, 0);
      smp();
      check("rd_t2_vld", deq_valid, 0);
      smp();
      check("rd_t3_vld", deq_valid, 1);
      check("rd_t3_pc", deq_pc, 32'h200);
      repeat (4) smp();

      // Fill to 3 under backpressure, then redirect with deq_ready high.
      drv();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h300;
      deq_ready      = 1'b0;
      exp_q.delete();
      base = n_pops;
      drv();
      redirect_valid = 1'b0;
      repeat (4) drv();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFA;
      deq_ready      = 1'b1;
      exp_q.delete();
      expect_run(32'hFFFF_FFF8, 20);
      smp();
      check("rdq_count3", count, 3);
      check("rdq_deq_valid", deq_valid, 0);
      check("rdq_req", imem_req, 0);
      drv();
      redirect_valid = 1'b0;
      smp();
      check("rdq_empty", count, 0);
      check("rdq_no_pop", 32'(n_pops - base), 0);
      smp();
      check("wrap_vld0", deq_valid, 0);
      smp();
      check("wrap_pc0", deq_pc, 32'hFFFF_FFF8);
      smp();
      check("wrap_pc1", deq_pc, 32'hFFFF_FFFC);
      smp();
      check("wrap_pc2", deq_pc, 32'h0000_0000);
      repeat (3) smp();
      drv();
      check("wrap_pops", 32'(n_pops - base), 6);

      // Opcode screening words.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1000;
      exp_q.delete();
      expect_run(32'h1000, 20);
      drv();
      redirect_valid = 1'b0;
      smp();
      smp();
      smp();
      check("op_pc0", deq_pc, 32'h1000);
      check("op_instr0", deq_instr, 32'h73);
`ifdef IFQ_OPCODE_CHECK_EN
      check("op_illegal0", deq_illegal, 1);
`endif
      smp();
      check("op_instr1", deq_instr, 32'h13);
`ifdef IFQ_OPCODE_CHECK_EN
      check("op_illegal1", deq_illegal, 0);
`endif
      repeat (2) smp();

      // Asynchronous reset in the middle of streaming.
      drv();
      rstn = 1'b0;
      exp_q.delete();
      smp();
      check_reset();
      expect_run(32'h0, 40);
      base = n_pops;
      rstn = 1'b1;
      smp();
      check("mr_c1_vld", deq_valid, 0);
      smp();
      check("mr_c2_vld", deq_valid, 1);
      check("mr_c2_pc", deq_pc, 32'h0);
      repeat (4) smp();
      drv();
      check("mr_pops", 32'(n_pops - base), 5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
